// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with a hold limit.
// Outputs a registered one-hot grant, its encoded index and a valid flag.
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid
);

   typedef enum logic {IDLE, BUSY} state_e;

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
   localparam bit               LIMITED  = (MAX_HOLD != 0);

   state_e           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [7:0]       gnt_q, gnt_d;
   logic [2:0]       idx_q, idx_d;
   logic             valid_q, valid_d;

   logic [2:0]       win;
   logic [2:0]       j;
   logic             any_req;
   logic             release_w;

   assign any_req   = |req;
   assign release_w = !req[idx_q] ||
                      (LIMITED && (hold_q == HOLD_LIM));

   // Scan from the highest offset down so the lowest offset wins.
   always_comb begin
      win = ptr_q;
      j   = '0;
      for (int k = 7; k >= 0; k--) begin
         j = ptr_q + 3'(k);
         if (req[j]) win = j;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (any_req)   state_d = BUSY;
         BUSY: if (release_w) state_d = IDLE;
         default:             state_d = IDLE;
      endcase
   end

   always_comb begin
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_d   = 8'b1 << win;
               idx_d   = win;
               valid_d = 1'b1;
               hold_d  = CNT_W'(1);
            end
         end
         BUSY: begin
            if (release_w) begin
               gnt_d   = '0;
               idx_d   = '0;
               valid_d = 1'b0;
               hold_d  = '0;
               ptr_d   = idx_q + 3'd1;
            end else if (hold_q != '1) begin
               // Saturates so an unlimited hold cannot wrap.
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: vector table, queued expectations
// and hand-written hold-limit and reset sequences.
module tb_rr_arbiter8;

   localparam int MAX_HOLD = 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] req   = 8'h00;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;

   always #5 clk = ~clk;

   rr_arbiter8 #(
      .MAX_HOLD(MAX_HOLD),
      .CNT_W   (5)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .gnt_valid(gnt_valid)
   );

   typedef struct {
      logic [7:0] req;
      logic       valid;
      logic [2:0] idx;
   } vec_t;

   typedef struct {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
   } exp_t;

   exp_t sbq[$];
   vec_t tbl[10];
   int   passed = 0;
   int   total  = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(logic v, logic [2:0] i);
      exp_t e;
      e.valid = v;
      e.idx   = v ? i : 3'd0;
      e.gnt   = v ? (8'h01 << i) : 8'h00;
      sbq.push_back(e);
   endtask

   task automatic step(string name, logic [7:0] r, logic v, logic [2:0] i);
      exp_t e;
      push(v, i);
      req = r;
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         check({name, "_queue"}, 0, 1);
      end else begin
         e = sbq.pop_front();
         check({name, "_gnt"}, gnt, e.gnt);
         check({name, "_idx"}, gnt_idx, e.idx);
         check({name, "_valid"}, gnt_valid, e.valid);
      end
   endtask

   task automatic check_zero(string name);
      check({name, "_gnt"}, gnt, 0);
      check({name, "_idx"}, gnt_idx, 0);
      check({name, "_valid"}, gnt_valid, 0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("inv_valid", gnt_valid, (gnt != 8'h00));
         check("inv_onehot0", $onehot0(gnt), 1);
         if (gnt_valid) check("inv_gnt_idx", gnt, 8'h01 << gnt_idx);
         else check("inv_idx_zero", gnt_idx, 0);
      end
   end

   initial begin
      tbl[0] = '{8'h05, 1'b1, 3'd0};
      tbl[1] = '{8'h04, 1'b0, 3'd0};
      tbl[2] = '{8'h04, 1'b1, 3'd2};
      tbl[3] = '{8'h00, 1'b0, 3'd0};
      tbl[4] = '{8'h40, 1'b1, 3'd6};
      tbl[5] = '{8'h00, 1'b0, 3'd0};
      tbl[6] = '{8'h81, 1'b1, 3'd7};
      tbl[7] = '{8'h01, 1'b0, 3'd0};
      tbl[8] = '{8'h01, 1'b1, 3'd0};
      tbl[9] = '{8'h00, 1'b0, 3'd0};

      #1 rst_n = 1'b0;
      #1 check_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int n = 0; n < 20; n++) step("idle", 8'h00, 1'b0, 3'd0);

      for (int n = 0; n < 10; n++)
         step("table", tbl[n].req, tbl[n].valid, tbl[n].idx);

      for (int n = 0; n < 40; n++)
         step("hold8", 8'h08, ((n % 17) < 16), 3'd3);
      step("hold8_rel", 8'h00, 1'b0, 3'd0);

      for (int n = 0; n < 51; n++)
         step("alt", 8'h18, ((n % 17) < 16),
              (((n / 17) % 2) == 0) ? 3'd4 : 3'd3);
      step("alt_rel", 8'h00, 1'b0, 3'd0);

      step("ign_gnt", 8'h02, 1'b1, 3'd1);
      for (int n = 0; n < 10; n++)
         step("ign", {6'($urandom), 2'b10}, 1'b1, 3'd1);
      step("ign_rel", {6'($urandom), 2'b00}, 1'b0, 3'd0);
      step("ign_idle", 8'h00, 1'b0, 3'd0);

      for (int n = 0; n < 7; n++) step("rst_pre", 8'h20, 1'b1, 3'd5);
      #3 rst_n = 1'b0;
      #1 check_zero("async_rst");
      #1 rst_n = 1'b1;
      for (int n = 0; n < 16; n++) step("rst_post", 8'h20, 1'b1, 3'd5);
      step("rst_post_dead", 8'h20, 1'b0, 3'd0);

      #3 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      step("ptr_reset", 8'hFF, 1'b1, 3'd0);
      step("ptr_rel", 8'hFE, 1'b0, 3'd0);
      step("ptr_next", 8'hFE, 1'b1, 3'd1);
      step("end_rel", 8'h00, 1'b0, 3'd0);

      check("sb_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
